// File: rtl/i2s_pattern_source.sv
// I2S slave transmitter that shifts constant, ramp or LFSR test patterns onto DIN, following
// the receiver's BCLK/WS. Define I2S_SRC_LFSR_EN to build the LFSR generator; otherwise mode 2 acts as constant.
module i2s_pattern_source #(
  parameter int          SAMPLE_W  = 24,
  parameter int          SLOT_W    = 32,
  parameter int          RAMP_STEP = 1,
  parameter logic [31:0] LFSR_SEED = 32'h0000_0001
) (
  input  logic                HCLK,
  input  logic                HRESET,
  input  logic                en,
  input  logic [1:0]          mode,
  input  logic                stereo,
  input  logic [SAMPLE_W-1:0] const_val,
  input  logic                BCLK,
  input  logic                WS,
  output logic                DIN,
  output logic [15:0]         frame_cnt,
  output logic                sample_strobe
);

  localparam logic [1:0] MODE_RAMP = 2'd1;

  // Per-frame state captured at the left slot start; the right slot replays it.
  typedef struct packed {
    logic                active;
    logic                stereo;
    logic [SAMPLE_W-1:0] left;
  } frame_t;

  logic [1:0]          bclk_sync, ws_sync;
  logic                bclk_d, bclk_rise, bclk_fall;
  logic                ws_q, armed;
  logic                load, load_left;
  logic [SAMPLE_W-1:0] ramp_acc, gen_val, left_val, right_val;
  logic [SLOT_W-1:0]   word, shreg;
  logic [5:0]          bits_sent;
  frame_t              frm;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      bclk_sync <= '0;
      ws_sync   <= '0;
      bclk_d    <= 1'b0;
    end else begin
      bclk_sync <= {bclk_sync[0], BCLK};
      ws_sync   <= {ws_sync[0], WS};
      bclk_d    <= bclk_sync[1];
    end
  end

  assign bclk_rise = bclk_sync[1] & ~bclk_d;
  assign bclk_fall = ~bclk_sync[1] & bclk_d;

  // A WS change seen on a rise arms a slot start; the following fall loads the word (one-BCLK delay).
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      ws_q  <= 1'b0;
      armed <= 1'b0;
    end else if (bclk_rise) begin
      ws_q <= ws_sync[1];
      if (ws_sync[1] != ws_q) armed <= 1'b1;
    end else if (bclk_fall) begin
      armed <= 1'b0;
    end
  end

  assign load      = bclk_fall & armed;
  assign load_left = load & ~ws_q;

`ifdef I2S_SRC_LFSR_EN
  localparam logic [1:0] MODE_LFSR = 2'd2;
  logic [31:0] lfsr;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET)                                 lfsr <= LFSR_SEED;
    else if (load_left && en && mode == MODE_LFSR) lfsr <= {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};
  end
`else
  logic unused_seed;
  assign unused_seed = ^LFSR_SEED;
`endif

  always_comb begin
    gen_val = const_val;
    case (mode)
      MODE_RAMP: gen_val = ramp_acc;
`ifdef I2S_SRC_LFSR_EN
      MODE_LFSR: gen_val = lfsr[SAMPLE_W-1:0];
`endif
      default:   gen_val = const_val;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET)                                    ramp_acc <= '0;
    else if (load_left && en && mode == MODE_RAMP) ramp_acc <= ramp_acc + SAMPLE_W'(RAMP_STEP);
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      frm           <= '0;
      frame_cnt     <= '0;
      sample_strobe <= 1'b0;
    end else begin
      sample_strobe <= load_left & en;
      if (load_left) begin
        frm.active <= en;
        frm.stereo <= stereo;
        frm.left   <= left_val;
        if (en) frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

  assign left_val = en ? gen_val : '0;

  always_comb begin
    right_val = '0;
    if (frm.active) right_val = frm.stereo ? (~frm.left + SAMPLE_W'(1)) : frm.left;
  end

  // Sample MSB-aligned in the slot, unused LSBs zero.
  always_comb begin
    word = '0;
    word[SLOT_W-1 -: SAMPLE_W] = load_left ? left_val : right_val;
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      shreg     <= '0;
      bits_sent <= 6'(SLOT_W);
      DIN       <= 1'b0;
    end else if (load) begin
      shreg     <= word;
      bits_sent <= 6'd1;
      DIN       <= word[SLOT_W-1];
    end else if (bclk_fall) begin
      if (bits_sent < 6'(SLOT_W)) begin
        shreg     <= shreg << 1;
        bits_sent <= bits_sent + 6'd1;
        DIN       <= shreg[SLOT_W-2];
      end else begin
        DIN <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_pattern_source.sv
// Bench for i2s_pattern_source: directed vector table, random frames against a frame-level model,
// and hand sequences for short slots, missing WS toggles, mid-frame disable and mid-slot reset.
module tb_i2s_pattern_source;
  localparam int SW = 24;
  localparam int SL = 32;

  typedef struct {
    logic          en;
    logic [1:0]    mode;
    logic          stereo;
    logic [SW-1:0] cv;
    logic [31:0]   exp_l;
    logic [31:0]   exp_r;
    logic [15:0]   exp_cnt;
  } vec_t;

  logic          HCLK = 1'b0, HRESET = 1'b1;
  logic          en = 1'b0, stereo = 1'b0, BCLK = 1'b1, WS = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [SW-1:0] const_val = '0;
  logic          DIN, sample_strobe;
  logic [15:0]   frame_cnt;

  int n_chk = 0, n_fail = 0, strobes = 0;

  // model state
  int          m_acc;
  logic [31:0] m_lfsr;
  int          m_cnt;

  i2s_pattern_source #(.SAMPLE_W(SW), .SLOT_W(SL), .RAMP_STEP(1), .LFSR_SEED(32'h1)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .en(en), .mode(mode), .stereo(stereo), .const_val(const_val),
    .BCLK(BCLK), .WS(WS), .DIN(DIN), .frame_cnt(frame_cnt), .sample_strobe(sample_strobe)
  );

  always #5 HCLK = ~HCLK;

  always @(negedge HCLK) if (sample_strobe === 1'b1) strobes <= strobes + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_acc = 0; m_lfsr = 32'h1; m_cnt = 0;
  endtask

  // Frame-level reference: one sample per enabled frame, words MSB-aligned in SL bits.
  task automatic model_frame(input logic e, input logic [1:0] md, input logic st, input logic [SW-1:0] cv,
                             output logic [31:0] l, output logic [31:0] r);
    int s, neg;
    l = 32'h0; r = 32'h0;
    if (!e) return;
    s = int'(cv);
    if (md == 2'd1) begin
      s = m_acc;
      m_acc = (m_acc + 1) % (2**SW);
    end
`ifdef I2S_SRC_LFSR_EN
    else if (md == 2'd2) begin
      s = int'(m_lfsr) % (2**SW);
      m_lfsr = (m_lfsr << 1) | 32'(^(m_lfsr & 32'h8020_0003));
    end
`endif
    neg = (2**SW - s) % (2**SW);
    l = 32'(s) << (SL - SW);
    r = (st ? 32'(neg) : 32'(s)) << (SL - SW);
    m_cnt = (m_cnt + 1) % 65536;
  endtask

  // One BCLK period: WS changes on the fall, DIN captured just before the rise.
  task automatic bclk_cycle(input logic ws, output logic d);
    @(negedge HCLK); BCLK = 1'b0; WS = ws;
    repeat (5) @(negedge HCLK);
    d = DIN; BCLK = 1'b1;
    repeat (4) @(negedge HCLK);
  endtask

  // n bits of slot ws_now; WS moves to ws_next during the last bit.
  task automatic slot(input logic ws_now, input logic ws_next, input int n, output logic [31:0] w);
    logic d;
    w = 32'h0;
    for (int i = 0; i < n; i++) begin
      bclk_cycle((i == n - 1) ? ws_next : ws_now, d);
      w = {w[30:0], d};
    end
  endtask

  task automatic run_frame(input logic e, input logic [1:0] md, input logic st, input logic [SW-1:0] cv,
                           input bit perturb, output logic [31:0] l, output logic [31:0] r);
    en = e; mode = md; stereo = st; const_val = cv;
    slot(1'b0, 1'b1, SL, l);
    if (perturb) begin
      en = 1'($urandom); mode = 2'($urandom); stereo = 1'($urandom); const_val = SW'($urandom);
    end
    slot(1'b1, 1'b0, SL, r);
  endtask

  initial begin
    vec_t        tbl [9];
    logic [31:0] l, r, el, er, a, b;
    logic        d, e, st;
    logic [1:0]  md;
    logic [SW-1:0] cv;
    int          s0;

    tbl[0] = '{1'b1, 2'd0, 1'b1, 24'h123456, 32'h12345600, 32'hEDCBAA00, 16'd1};
    tbl[1] = '{1'b1, 2'd1, 1'b0, 24'h777777, 32'h00000000, 32'h00000000, 16'd2};
    tbl[2] = '{1'b1, 2'd1, 1'b1, 24'h000000, 32'h00000100, 32'hFFFFFF00, 16'd3};
    tbl[3] = '{1'b0, 2'd1, 1'b1, 24'h5A5A5A, 32'h00000000, 32'h00000000, 16'd3};
    tbl[4] = '{1'b1, 2'd1, 1'b0, 24'h000000, 32'h00000200, 32'h00000200, 16'd4};
`ifdef I2S_SRC_LFSR_EN
    tbl[5] = '{1'b1, 2'd2, 1'b0, 24'h0000AA, 32'h00000100, 32'h00000100, 16'd5};
    tbl[6] = '{1'b1, 2'd2, 1'b0, 24'h0000AA, 32'h00000300, 32'h00000300, 16'd6};
`else
    tbl[5] = '{1'b1, 2'd2, 1'b0, 24'h0000AA, 32'h0000AA00, 32'h0000AA00, 16'd5};
    tbl[6] = '{1'b1, 2'd2, 1'b0, 24'h0000AA, 32'h0000AA00, 32'h0000AA00, 16'd6};
`endif
    tbl[7] = '{1'b1, 2'd3, 1'b1, 24'hABCDEF, 32'hABCDEF00, 32'h54321100, 16'd7};
    tbl[8] = '{1'b1, 2'd1, 1'b0, 24'h000000, 32'h00000300, 32'h00000300, 16'd8};

    model_reset();
    repeat (3) @(negedge HCLK);
    check("reset DIN", 32'(DIN), 32'h0);
    check("reset frame_cnt", 32'(frame_cnt), 32'h0);
    check("reset strobe", 32'(sample_strobe), 32'h0);
    HRESET = 1'b0;

    // lead-in right slot; nothing is sent before a left slot start
    bclk_cycle(1'b1, d);
    slot(1'b1, 1'b0, SL, r);
    check("lead-in right", r, 32'h0);

    foreach (tbl[i]) begin
      s0 = strobes;
      run_frame(tbl[i].en, tbl[i].mode, tbl[i].stereo, tbl[i].cv, 1'b1, l, r);
      model_frame(tbl[i].en, tbl[i].mode, tbl[i].stereo, tbl[i].cv, el, er);
      check($sformatf("vec%0d left", i), l, tbl[i].exp_l);
      check($sformatf("vec%0d right", i), r, tbl[i].exp_r);
      check($sformatf("vec%0d frame_cnt", i), 32'(frame_cnt), 32'(tbl[i].exp_cnt));
      check($sformatf("vec%0d strobes", i), 32'(strobes - s0), 32'(tbl[i].en));
    end

    for (int i = 0; i < 20; i++) begin
      e = ($urandom_range(3, 0) != 0); md = 2'($urandom); st = 1'($urandom); cv = SW'($urandom);
      s0 = strobes;
      run_frame(e, md, st, cv, 1'b1, l, r);
      model_frame(e, md, st, cv, el, er);
      check($sformatf("rand%0d left", i), l, el);
      check($sformatf("rand%0d right", i), r, er);
      check($sformatf("rand%0d frame_cnt", i), 32'(frame_cnt), 32'(m_cnt));
      check($sformatf("rand%0d strobes", i), 32'(strobes - s0), 32'(e));
    end

    // short left slot: truncated after 8 bits, right slot unaffected
    cv = SW'($urandom);
    en = 1'b1; mode = 2'd0; stereo = 1'b1; const_val = cv;
    model_frame(1'b1, 2'd0, 1'b1, cv, el, er);
    slot(1'b0, 1'b1, 8, a);
    slot(1'b1, 1'b0, SL, r);
    check("short left", a, 32'(el[31:24]));
    check("short right", r, er);

    // no WS toggle after a full slot: DIN stays 0
    cv = SW'($urandom) | 24'h800001;
    en = 1'b1; mode = 2'd0; stereo = 1'b0; const_val = cv;
    model_frame(1'b1, 2'd0, 1'b0, cv, el, er);
    slot(1'b0, 1'b1, SL, l);
    slot(1'b1, 1'b1, SL, r);
    slot(1'b1, 1'b0, 8, a);
    check("notoggle left", l, el);
    check("notoggle right", r, er);
    check("notoggle tail", a, 32'h0);

    // en drops mid-left-slot: frame completes, following frame is silent, ramp resumes
    en = 1'b1; mode = 2'd1; stereo = 1'b0;
    model_frame(1'b1, 2'd1, 1'b0, const_val, el, er);
    slot(1'b0, 1'b0, 16, a);
    en = 1'b0;
    slot(1'b0, 1'b1, 16, b);
    slot(1'b1, 1'b0, SL, r);
    check("endrop left", {a[15:0], b[15:0]}, el);
    check("endrop right", r, er);
    run_frame(1'b0, 2'd1, 1'b0, const_val, 1'b0, l, r);
    check("disabled frame", l | r, 32'h0);
    check("disabled frame_cnt", 32'(frame_cnt), 32'(m_cnt));
    run_frame(1'b1, 2'd1, 1'b0, const_val, 1'b0, l, r);
    model_frame(1'b1, 2'd1, 1'b0, const_val, el, er);
    check("reenable left", l, el);

    // reset mid-slot: DIN drops at once, then the ramp restarts from 0
    en = 1'b1; mode = 2'd0; stereo = 1'b0; const_val = 24'hFFFFFF;
    slot(1'b1, 1'b0, SL, r);
    slot(1'b0, 1'b0, 4, a);
    check("pre-reset bits", a, 32'hF);
    @(negedge HCLK); HRESET = 1'b1; #1;
    check("reset DIN async", 32'(DIN), 32'h0);
    check("reset frame_cnt mid", 32'(frame_cnt), 32'h0);
    repeat (2) @(negedge HCLK); HRESET = 1'b0;
    model_reset();
    slot(1'b0, 1'b1, SL - 4, a);
    check("post-reset left idle", a, 32'h0);
    slot(1'b1, 1'b0, SL, r);
    check("post-reset right idle", r, 32'h0);
    s0 = strobes;
    for (int i = 0; i < 4; i++) begin
      run_frame(1'b1, 2'd1, 1'b0, 24'h0, 1'b0, l, r);
      check($sformatf("ramp%0d left", i), l, 32'(i) << 8);
      check($sformatf("ramp%0d right", i), r, 32'(i) << 8);
    end
    check("ramp frame_cnt", 32'(frame_cnt), 32'd4);
    check("ramp strobes", 32'(strobes - s0), 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
